// File: rtl/systolic_seq.sv
// systolic_seq: operand sequencer for a 2x2 systolic tile array.
//
// Holds an operand buffer of 8-bit elements: A rows (cfg_sel=0) and
// B columns (cfg_sel=1), two lanes each, K elements per lane. On start it
// streams each lane as 2-cycle nibble frames (high nibble with ctrl=1,
// then low nibble with ctrl=0). Lane 1 runs SKEW cycles behind lane 0.
// After streaming, it spends DRAIN cycles in DRAIN and then pulses done.
// While a run is active, it reassembles 8-bit result frames from the
// bottom-edge nibble outputs.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_we/sel/lane/idx/data  buffer write, accepted only in IDLE
//   start                     begin a run, accepted only in IDLE and not in the done cycle
//   busy, done                run in progress, one-cycle completion pulse
//   row_in/row_ctrl_in        row-edge nibbles and frame strobes (lane 0, lane 1)
//   col_in/col_ctrl_in        column-edge nibbles and frame strobes
//   col_out/col_ctrl_out      bottom-edge result nibbles and strobes
//   res_valid/res_data        per-lane result pulse and byte (byte holds between pulses)
//   perf_results              present only with SYSTOLIC_SEQ_PERF_EN defined; saturating
//                             count of result bytes in the current or most recent run
module systolic_seq #(
  parameter int K     = 4,
  parameter int SKEW  = 2,
  parameter int DRAIN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic                 cfg_lane,
  input  logic [$clog2(K)-1:0] cfg_idx,
  input  logic [7:0]           cfg_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0][3:0]      row_in,
  output logic [1:0]           row_ctrl_in,
  output logic [1:0][3:0]      col_in,
  output logic [1:0]           col_ctrl_in,
  input  logic [1:0][3:0]      col_out,
  input  logic [1:0]           col_ctrl_out,
  output logic [1:0]           res_valid,
  output logic [1:0][7:0]      res_data
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [7:0]           perf_results
`endif
);

  localparam int          IW    = $clog2(K);
  localparam int unsigned SK    = SKEW;
  localparam int unsigned FLEN  = 2 * K;
  localparam logic [7:0]  SLAST = 8'(2 * K + SKEW - 1);
  localparam logic [7:0]  DLAST = 8'(DRAIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t                       r_state, w_state_nxt;
  logic [7:0]                   r_cnt, w_cnt_nxt;
  logic                         r_done, w_done_nxt;
  logic                         w_start_acc;
  // Indexed [sel][lane][idx].
  logic [1:0][1:0][K-1:0][7:0]  r_buf, w_buf_nxt;
  logic [1:0][3:0]              r_row, r_col;
  logic [1:0]                   r_rowc, r_colc;
  logic [4:0]                   w_fa0, w_fa1, w_fb0, w_fb1;
  int unsigned                  w_s0, w_s1;
  logic [1:0]                   r_ph;
  logic [1:0][3:0]              r_hi;
  logic [1:0]                   r_rv;
  logic [1:0][7:0]              r_rd;

  // Returns {ctrl, nibble} for frame position t of a lane. Positions at
  // or beyond 2K are outside any frame and yield zero.
  function automatic logic [4:0] f_frame(input logic [K-1:0][7:0] lane,
                                         input int unsigned t);
    logic [7:0] e;
    logic [4:0] r;
    r = '0;
    if (t < FLEN) begin
      e = lane[IW'(t >> 1)];
      r = t[0] ? {1'b0, e[3:0]} : {1'b1, e[7:4]};
    end
    return r;
  endfunction

  always_comb begin
    // A write in the same cycle as start must be visible to the run,
    // so the next-buffer value also feeds the first stream outputs.
    w_buf_nxt = r_buf;
    if (cfg_we && (r_state == S_IDLE))
      w_buf_nxt[cfg_sel][cfg_lane][cfg_idx] = cfg_data;

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_start_acc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !r_done) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_STREAM;
          w_cnt_nxt   = '0;
        end
      end
      S_STREAM: begin
        if (r_cnt == SLAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DLAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Stream outputs are registered from the next count, so that frame
    // position 0 appears in the first cycle after start is accepted.
    w_s0  = 32'(w_cnt_nxt);
    w_s1  = (w_s0 >= SK) ? (w_s0 - SK) : FLEN;
    w_fa0 = '0;
    w_fa1 = '0;
    w_fb0 = '0;
    w_fb1 = '0;
    if (w_state_nxt == S_STREAM) begin
      w_fa0 = f_frame(w_buf_nxt[0][0], w_s0);
      w_fa1 = f_frame(w_buf_nxt[0][1], w_s1);
      w_fb0 = f_frame(w_buf_nxt[1][0], w_s0);
      w_fb1 = f_frame(w_buf_nxt[1][1], w_s1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_buf   <= '0;
      r_row   <= '0;
      r_rowc  <= '0;
      r_col   <= '0;
      r_colc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_buf   <= w_buf_nxt;
      r_row   <= {w_fa1[3:0], w_fa0[3:0]};
      r_rowc  <= {w_fa1[4], w_fa0[4]};
      r_col   <= {w_fb1[3:0], w_fb0[3:0]};
      r_colc  <= {w_fb1[4], w_fb0[4]};
    end
  end

  // Result assembly per lane. A strobe always starts a new byte, even
  // in the low-nibble cycle. A partial byte is discarded once the
  // sequencer is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph <= '0;
      r_hi <= '0;
      r_rv <= '0;
      r_rd <= '0;
    end else begin
      for (int unsigned l = 0; l < 2; l++) begin
        r_rv[l] <= 1'b0;
        if (r_state == S_IDLE) begin
          r_ph[l] <= 1'b0;
        end else if (col_ctrl_out[l]) begin
          r_hi[l] <= col_out[l];
          r_ph[l] <= 1'b1;
        end else if (r_ph[l]) begin
          r_rd[l] <= {r_hi[l], col_out[l]};
          r_rv[l] <= 1'b1;
          r_ph[l] <= 1'b0;
        end
      end
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [7:0] r_perf;
  logic [8:0] w_perf_sum;

  always_comb begin
    w_perf_sum = {1'b0, r_perf} + {8'd0, r_rv[0]} + {8'd0, r_rv[1]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_perf <= '0;
    else if (w_start_acc)
      r_perf <= '0;
    else
      r_perf <= w_perf_sum[8] ? 8'hFF : w_perf_sum[7:0];
  end

  assign perf_results = r_perf;
`endif

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign row_in      = r_row;
  assign row_ctrl_in = r_rowc;
  assign col_in      = r_col;
  assign col_ctrl_in = r_colc;
  assign res_valid   = r_rv;
  assign res_data    = r_rd;

endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: self-checking bench for systolic_seq (K=4, SKEW=2, DRAIN=8).
// Expected stream frames and result bytes are queued when stimulus is
// driven, then popped and compared when the DUT produces them.
// Build with SYSTOLIC_SEQ_PERF_EN to also cover perf_results.
module tb_systolic_seq;
  localparam int K     = 4;
  localparam int SKEW  = 2;
  localparam int DRAIN = 8;
  localparam int NACT  = 2 * K + SKEW + DRAIN;  // busy cycles per run

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_we = 1'b0, cfg_sel = 1'b0, cfg_lane = 1'b0;
  logic [1:0]      cfg_idx = '0;
  logic [7:0]      cfg_data = '0;
  logic            start = 1'b0;
  logic            busy, done;
  logic [1:0][3:0] row_in, col_in;
  logic [1:0]      row_ctrl_in, col_ctrl_in;
  logic [1:0][3:0] col_out = '0;
  logic [1:0]      col_ctrl_out = '0;
  logic [1:0]      res_valid;
  logic [1:0][7:0] res_data;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [7:0]      perf_results;
`endif

  systolic_seq #(.K(K), .SKEW(SKEW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_lane(cfg_lane), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done),
    .row_in(row_in), .row_ctrl_in(row_ctrl_in),
    .col_in(col_in), .col_ctrl_in(col_ctrl_in),
    .col_out(col_out), .col_ctrl_out(col_ctrl_out),
    .res_valid(res_valid), .res_data(res_data)
`ifdef SYSTOLIC_SEQ_PERF_EN
    , .perf_results(perf_results)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Bench model of the operand buffer, indexed [sel][lane][idx].
  logic [7:0] mdl [2][2][K];

  typedef struct packed {
    logic [1:0]  m;
    logic [15:0] d;
  } res_t;
  res_t        exp_q [$];
  logic [21:0] str_q [$];
  int          n_bits;

  // Per-cycle result-edge stimulus for a run: index 0 is the first busy cycle.
  logic [1:0] drv_ctrl [NACT+1];
  logic [7:0] drv_data [NACT+1];

  task automatic clear_drv();
    for (int i = 0; i <= NACT; i++) begin
      drv_ctrl[i] = '0;
      drv_data[i] = '0;
    end
  endtask

  // Result scoreboard: every result pulse must match the oldest queued expectation.
  res_t        mon_e;
  logic [15:0] mon_g;
  always @(negedge clk) begin
    if (res_valid !== 2'b00) begin
      mon_g = {res_valid[1] ? res_data[1] : 8'h00, res_valid[0] ? res_data[0] : 8'h00};
      if (exp_q.size() == 0) begin
        chk("res_unexpected", {14'd0, res_valid, mon_g}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res", {14'd0, res_valid, mon_g}, {14'd0, mon_e.m, mon_e.d});
      end
    end
  end

  function automatic logic [21:0] exp_cycle(input int i);
    logic [1:0] rc, cc;
    logic [7:0] rn, cn;
    logic [7:0] e;
    int t;
    rc = '0; cc = '0; rn = '0; cn = '0;
    for (int sel = 0; sel < 2; sel++) begin
      for (int ln = 0; ln < 2; ln++) begin
        t = i - (ln == 1 ? SKEW : 0);
        if (t >= 0 && t < 2 * K) begin
          e = mdl[sel][ln][t / 2];
          if (sel == 0) begin
            rc[ln] = (t % 2 == 0);
            rn[ln*4 +: 4] = (t % 2 == 0) ? e[7:4] : e[3:0];
          end else begin
            cc[ln] = (t % 2 == 0);
            cn[ln*4 +: 4] = (t % 2 == 0) ? e[7:4] : e[3:0];
          end
        end
      end
    end
    return {(i < NACT), (i == NACT), rc, cc, rn, cn};
  endfunction

  task automatic wr(input bit sel, input bit ln, input int idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_lane = ln; cfg_idx = 2'(idx); cfg_data = d;
    mdl[sel][ln][idx] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One run. abort_at >= 0 asserts rst during that stream count.
  // wr_at_start writes A[1][3] in the start cycle. wr_mid drives an
  // ignored write and start in STREAM, and start in the done cycle.
  task automatic do_run(input string nm, input int abort_at, input bit wr_at_start, input bit wr_mid);
    logic [1:0] ph;
    logic [1:0][3:0] hi;
    res_t r;
    logic [21:0] ex;
    bit saw_done;
    start = 1'b1;
    if (wr_at_start) begin
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_lane = 1'b1; cfg_idx = 2'd3; cfg_data = 8'h9D;
      mdl[0][1][3] = 8'h9D;
    end
    str_q.delete();
    for (int i = 0; i <= NACT; i++) str_q.push_back(exp_cycle(i));
    ph = '0; hi = '0; n_bits = 0;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i <= NACT; i++) begin
      ex = str_q.pop_front();
      chk($sformatf("%s_stream_c%0d", nm, i),
          {10'd0, busy, done, row_ctrl_in, col_ctrl_in, row_in, col_in}, {10'd0, ex});
`ifdef SYSTOLIC_SEQ_PERF_EN
      if (i == 0) chk($sformatf("%s_perf_clear", nm), {24'd0, perf_results}, 32'd0);
`endif
      start = 1'b0; cfg_we = 1'b0;
      if (i == abort_at) begin
        rst = 1'b1;
        col_ctrl_out = '0; col_out = '0;
        @(negedge clk);
        chk($sformatf("%s_rst_outputs", nm),
            {busy, done, row_ctrl_in, col_ctrl_in, row_in, col_in, res_valid},
            32'd0);
        chk($sformatf("%s_rst_resdata", nm), {16'd0, res_data}, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int j = 0; j < NACT + 4; j++) begin
          @(negedge clk);
          saw_done = saw_done | (done === 1'b1) | (busy === 1'b1);
        end
        chk($sformatf("%s_no_done_after_rst", nm), {31'd0, saw_done}, 32'd0);
        str_q.delete();
        return;
      end
      col_ctrl_out = drv_ctrl[i];
      col_out = drv_data[i];
      if (i < NACT) begin
        r = '0;
        for (int l = 0; l < 2; l++) begin
          if (drv_ctrl[i][l]) begin
            ph[l] = 1'b1; hi[l] = drv_data[i][l*4 +: 4];
          end else if (ph[l]) begin
            r.m[l] = 1'b1;
            r.d[l*8 +: 8] = {hi[l], drv_data[i][l*4 +: 4]};
            ph[l] = 1'b0;
            n_bits++;
          end
        end
        if (r.m != 2'b00) exp_q.push_back(r);
      end
      if (wr_mid && i == 3) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_lane = 1'b0; cfg_idx = 2'd0; cfg_data = 8'hFF;
        start = 1'b1;
      end
      if (wr_mid && i == NACT) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0; cfg_we = 1'b0;
    col_ctrl_out = '0; col_out = '0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_idle_%0d", nm, j), {30'd0, busy, done}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int i = 0; i < K; i++) mdl[s][l][i] = 8'h00;
    clear_drv();

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {busy, done, row_ctrl_in, col_ctrl_in, row_in, col_in, res_valid}, 32'd0);
    chk("reset_resdata", {16'd0, res_data}, 32'd0);

    // Result strobes in IDLE must be ignored.
    for (int j = 0; j < 4; j++) begin
      col_ctrl_out = (j % 2 == 0) ? 2'b11 : 2'b00;
      col_out = 8'h5A;
      @(negedge clk);
      chk($sformatf("idle_strobe_%0d", j), {30'd0, res_valid}, 32'd0);
    end
    col_ctrl_out = '0; col_out = '0;

    wr(0, 0, 0, 8'h12); wr(0, 0, 1, 8'h34); wr(0, 0, 2, 8'h56); wr(0, 0, 3, 8'h78);
    wr(0, 1, 0, 8'h9A); wr(0, 1, 1, 8'hBC); wr(0, 1, 2, 8'hDE); wr(0, 1, 3, 8'hF0);
    wr(1, 0, 0, 8'h11); wr(1, 0, 1, 8'h22); wr(1, 0, 2, 8'h33); wr(1, 0, 3, 8'h44);
    wr(1, 1, 0, 8'hAB); wr(1, 1, 1, 8'hCD); wr(1, 1, 2, 8'hEF); wr(1, 1, 3, 8'h01);

    // Run 1: three lane-0 bytes, one dual-lane byte, an unfinished frame
    // at the end of DRAIN, and a strobe in the done cycle.
    clear_drv();
    drv_ctrl[2]  = 2'b01; drv_data[2]  = 8'h0C;
    drv_ctrl[3]  = 2'b00; drv_data[3]  = 8'h03;
    drv_ctrl[6]  = 2'b11; drv_data[6]  = 8'h95;
    drv_ctrl[7]  = 2'b00; drv_data[7]  = 8'h6A;
    drv_ctrl[13] = 2'b01; drv_data[13] = 8'h0D;
    drv_ctrl[14] = 2'b00; drv_data[14] = 8'h0E;
    drv_ctrl[15] = 2'b01; drv_data[15] = 8'h01;
    drv_ctrl[16] = 2'b00; drv_data[16] = 8'h02;
    drv_ctrl[17] = 2'b01; drv_data[17] = 8'h0F;
    drv_ctrl[18] = 2'b10; drv_data[18] = 8'h70;
    do_run("run1", -1, 1'b1, 1'b0);
    chk("run1_resdata_hold", {16'd0, res_data}, {16'd0, 8'h96, 8'h12});
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk("run1_perf", {24'd0, perf_results}, 32'd5);
    chk("run1_perf_model", n_bits, 32'd5);
`endif

    // Run 2: a lane-1 strobe in the low-nibble cycle restarts assembly;
    // write, start in STREAM and start in the done cycle are all ignored.
    clear_drv();
    drv_ctrl[10] = 2'b10; drv_data[10] = 8'h70;
    drv_ctrl[11] = 2'b10; drv_data[11] = 8'h80;
    drv_ctrl[12] = 2'b00; drv_data[12] = 8'h20;
    do_run("run2", -1, 1'b0, 1'b1);

    // Run 3: the buffer must still hold its pre-run-2 contents.
    clear_drv();
    do_run("run3", -1, 1'b0, 1'b0);

    // Run 4: reset at stream count 5 clears everything, including the buffers.
    do_run("run4", 5, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int i = 0; i < K; i++) mdl[s][l][i] = 8'h00;
    do_run("run5", -1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("res_queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
